mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM pipeline stage against a variable-latency memory with a req/ack handshake. Sits between the EX/MEM pipeline register outputs and the data memory. Freezes the front of the pipeline (F/D/E/M registers) with a stall until the access completes, and orders syscalls behind outstanding memory traffic.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
TIMEOUT, 255, max cycles in ACCESS before abort (timeout build only)
TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_to_reg_m  in  1  M-stage instruction is a load
mem_write_m  in  1  M-stage instruction is a store
syscall_m  in  1  M-stage instruction is a syscall
alu_out_m  in  ADDR_W  M-stage effective address
write_data_m  in  DATA_W  M-stage store data
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, registered, valid while mem_req
mem_addr  out  ADDR_W  registered request address
mem_wdata  out  DATA_W  registered store data
mem_ack  in  1  memory completion, single-cycle pulse
mem_rdata  in  DATA_W  load data, valid with mem_ack
read_data_m  out  DATA_W  captured load data, held until next load completes
stall_m  out  1  freeze F/D/E/M pipeline registers (combinational from state/inputs)
syscall_go  out  1  one-cycle pulse: syscall may execute
addr_err  out  1  one-cycle pulse: misaligned access dropped
timeout_err  out  1  sticky timeout flag (timeout build only, else tied 0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, syscall_go, addr_err, timeout_err = 0; mem_addr, mem_wdata, read_data_m = 0; counter = 0. mem_req drops immediately, even mid-ACCESS; an in-flight ack after reset is ignored.
- access_m = mem_to_reg_m | mem_write_m. If both are set, the store takes priority (mem_we=1).
- States: IDLE, ACCESS, DONE, SYS.
- IDLE, access_m=1, alu_out_m[1:0]==0: stall_m=1; at the clock edge, register mem_req=1, mem_we=mem_write_m, mem_addr=alu_out_m, mem_wdata=write_data_m; go to ACCESS.
- IDLE, access_m=1, misaligned: no request, no stall; addr_err pulses high the next cycle; stay IDLE.
- IDLE, syscall_m=1, access_m=0: stall_m=1; go to SYS; syscall_go=1 during the SYS cycle.
- IDLE, nothing pending: stall_m=0.
- ACCESS: stall_m=1; mem_req held with address and data stable until mem_ack.
  - On mem_ack: mem_req and mem_we clear at that edge; if a load, read_data_m <= mem_rdata; go to DONE.
  - Minimum access latency: request issued cycle N+1, ack at N+1 earliest, release in DONE cycle N+2.
- DONE: stall_m=0 for one cycle so the pipeline advances past the completed instruction; go to IDLE. Prevents re-issuing the same M-stage instruction.
- SYS: stall_m=0, syscall_go=1; go to IDLE.
- mem_ack in IDLE, DONE or SYS: ignored, no state change.
- Stores issued before a syscall complete first, because the syscall enters IDLE only after DONE.

Optional Feature:
MEM_ACCESS_TIMEOUT_EN:
- Defined: the counter resets on ACCESS entry and increments each ACCESS cycle without ack. When the count reaches TIMEOUT: drop mem_req, set timeout_err (sticky until reset), go to DONE; read_data_m is unchanged. An ack on the same cycle as the timeout wins (normal completion).
- Undefined: no counter, timeout_err tied 0, ACCESS waits indefinitely.

Test Plan:
- Load: mem_to_reg_m=1, addr 0x0000_0010, ack 3 cycles after req with rdata 0xDEADBEEF -> mem_req high 3 cycles, mem_we=0, stall_m high 4 cycles then low 1 (DONE), read_data_m=0xDEADBEEF.
- Store: mem_write_m=1, addr 0x20, data 0x12345678, ack same cycle as first req -> mem_we=1, mem_addr/mem_wdata stable, stall_m 2 cycles, read_data_m unchanged.
- Misaligned: load at 0x0000_0013 -> no mem_req, stall_m=0, addr_err single pulse.
- Syscall after store: store (ack delay 2) then syscall_m -> syscall_go pulses only after the store's DONE cycle, exactly one cycle wide.
- Reset mid-access: rst_n low during ACCESS -> mem_req=0 immediately, stall_m=0; a later ack is ignored; state IDLE.
- Timeout (macro defined, TIMEOUT=4): load with no ack -> mem_req drops after 4 ACCESS cycles, timeout_err=1 sticky, pipeline released through DONE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Sequences MEM-stage data-memory accesses against a variable-latency memory
// that uses a req/ack handshake. While an access is outstanding, the front of
// the pipeline (F/D/E/M registers) is frozen through stall_m. A syscall in the
// M stage gets a one-cycle syscall_go slot. That slot is granted only from
// IDLE, so any earlier memory traffic has already retired through DONE.
//
// Optional build feature (macro MEM_ACCESS_TIMEOUT_EN):
//   If defined, an access abandons the memory after TIMEOUT ACCESS cycles
//   without an ack. It then raises the sticky timeout_err flag. If undefined,
//   ACCESS waits indefinitely and timeout_err is tied low.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   mem_to_reg_m          M-stage instruction is a load
//   mem_write_m           M-stage instruction is a store (wins over load)
//   syscall_m             M-stage instruction is a syscall
//   alu_out_m             M-stage effective address
//   write_data_m          M-stage store data
//   mem_req/mem_we        registered request strobe and write enable
//   mem_addr/mem_wdata    registered request address and store data
//   mem_ack/mem_rdata     memory completion pulse and load data
//   read_data_m           last completed load data
//   stall_m               freeze F/D/E/M pipeline registers (combinational)
//   syscall_go            one-cycle pulse: syscall may execute
//   addr_err              one-cycle pulse: misaligned access dropped
//   timeout_err           sticky timeout flag (timeout build only)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_to_reg_m,
   input  logic              mem_write_m,
   input  logic              syscall_m,
   input  logic [ADDR_W-1:0] alu_out_m,
   input  logic [DATA_W-1:0] write_data_m,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] read_data_m,
   output logic              stall_m,
   output logic              syscall_go,
   output logic              addr_err,
   output logic              timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2,
      S_SYS    = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic w_access;
   logic w_aligned;
   logic w_issue;
   logic w_misalign;
   logic w_ack_done;
   logic w_timeout;
   logic r_addr_err;

   assign w_access   = mem_to_reg_m | mem_write_m;
   assign w_aligned  = (alu_out_m[1:0] == 2'b00);
   assign w_issue    = (r_state == S_IDLE) && w_access &&  w_aligned;
   assign w_misalign = (r_state == S_IDLE) && w_access && !w_aligned;
   assign w_ack_done = (r_state == S_ACCESS) && mem_ack;

   // Next-state and stall decode
   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      stall_m     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_issue) begin
               stall_m     = 1'b1;
               w_state_nxt = S_ACCESS;
            end else if (!w_access && syscall_m) begin
               stall_m     = 1'b1;
               w_state_nxt = S_SYS;
            end
         end
         S_ACCESS: begin
            stall_m = 1'b1;
            // An ack in the same cycle as a timeout is a normal completion.
            if (mem_ack || w_timeout) begin
               w_state_nxt = S_DONE;
            end
         end
         // DONE releases the pipeline for one cycle so the finished
         // instruction leaves M and is not issued again.
         S_DONE:  w_state_nxt = S_IDLE;
         S_SYS:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and memory-interface registers
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_addr_err  <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         read_data_m <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_addr_err <= w_misalign;
         if (w_issue) begin
            mem_req   <= 1'b1;
            mem_we    <= mem_write_m;
            mem_addr  <= alu_out_m;
            mem_wdata <= write_data_m;
         end else if (w_ack_done || w_timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            // Capture data only for a load that really completed.
            // A timed-out load leaves read_data_m untouched.
            if (w_ack_done && !mem_we) begin
               read_data_m <= mem_rdata;
            end
         end
      end
   end

   assign syscall_go = (r_state == S_SYS);
   assign addr_err   = r_addr_err;

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_timeout_err;

   // The counter holds the number of ACCESS cycles already spent without an
   // ack. The timeout fires on the cycle whose increment would reach TIMEOUT.
   assign w_timeout = (r_state == S_ACCESS) && !mem_ack &&
                      ((r_to_cnt + TO_ONE) == TO_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_issue) begin
            r_to_cnt <= '0;
         end else if (r_state == S_ACCESS && !mem_ack) begin
            r_to_cnt <= r_to_cnt + TO_ONE;
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   // Without the timeout build, the configuration parameters feed nothing.
   logic [TO_W-1:0] w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = TO_W'(TIMEOUT);

   assign w_timeout   = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed testbench for mem_access_ctrl. Inputs change 1 ns after each rising
// edge. Outputs are sampled 1 ns later, well away from the active edge. Each
// scenario task compares observed and hand-computed values inline.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk;
   logic              rst_n;
   logic              mem_to_reg_m;
   logic              mem_write_m;
   logic              syscall_m;
   logic [ADDR_W-1:0] alu_out_m;
   logic [DATA_W-1:0] write_data_m;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] read_data_m;
   logic              stall_m;
   logic              syscall_go;
   logic              addr_err;
   logic              timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   mem_access_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(4),
      .TO_W   (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_to_reg_m(mem_to_reg_m),
      .mem_write_m (mem_write_m),
      .syscall_m   (syscall_m),
      .alu_out_m   (alu_out_m),
      .write_data_m(write_data_m),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .read_data_m (read_data_m),
      .stall_m     (stall_m),
      .syscall_go  (syscall_go),
      .addr_err    (addr_err),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_to_reg_m = 1'b0;
      mem_write_m  = 1'b0;
      syscall_m    = 1'b0;
      mem_ack      = 1'b0;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      clear_inputs();
      alu_out_m    = '0;
      write_data_m = '0;
      mem_rdata    = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({mem_req, mem_we, stall_m, syscall_go, addr_err, timeout_err} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {mem_req, mem_we, stall_m, syscall_go, addr_err, timeout_err});
      end
      n_checks++;
      if ({mem_addr, mem_wdata, read_data_m} !== 96'h0) begin
         n_errors++;
         $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, read_data_m});
      end
      rst_n = 1'b1;
      cyc();
      n_checks++;
      if ({mem_req, stall_m} !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_release: got req/stall %b expected 00", {mem_req, stall_m});
      end
   endtask

   // Load at 0x10, ack in the third request cycle.
   task automatic test_load();
      int n_req = 0;
      int n_stall = 0;
      mem_to_reg_m = 1'b1;
      alu_out_m    = 32'h0000_0010;
      for (int k = 0; k < 7; k++) begin
         mem_ack   = (k == 3);
         mem_rdata = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
         if (k == 5) mem_to_reg_m = 1'b0;
         #1;
         if (mem_req) n_req++;
         if (stall_m) n_stall++;
         if (k == 2) begin
            n_checks++;
            if (mem_we !== 1'b0 || mem_addr !== 32'h10) begin
               n_errors++;
               $display("FAIL load_req_fields: got we=%b addr=%h expected we=0 addr=00000010",
                        mem_we, mem_addr);
            end
         end
         if (k == 4) begin
            n_checks++;
            if (stall_m !== 1'b0 || mem_req !== 1'b0) begin
               n_errors++;
               $display("FAIL load_done_cycle: got stall=%b req=%b expected 0 0", stall_m, mem_req);
            end
         end
         cyc();
      end
      clear_inputs();
      n_checks++;
      if (n_req != 3) begin
         n_errors++;
         $display("FAIL load_req_cycles: got %0d expected 3", n_req);
      end
      n_checks++;
      if (n_stall != 4) begin
         n_errors++;
         $display("FAIL load_stall_cycles: got %0d expected 4", n_stall);
      end
      n_checks++;
      if (read_data_m !== 32'hDEAD_BEEF) begin
         n_errors++;
         $display("FAIL load_rdata: got %h expected deadbeef", read_data_m);
      end
   endtask

   // Store at 0x20, ack in the first request cycle.
   task automatic test_store();
      int n_stall = 0;
      mem_write_m  = 1'b1;
      alu_out_m    = 32'h0000_0020;
      write_data_m = 32'h1234_5678;
      for (int k = 0; k < 5; k++) begin
         mem_ack   = (k == 1);
         mem_rdata = (k == 1) ? 32'hFFFF_FFFF : 32'h0;
         if (k == 3) mem_write_m = 1'b0;
         #1;
         if (stall_m) n_stall++;
         if (k == 1) begin
            n_checks++;
            if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h20 ||
                mem_wdata !== 32'h1234_5678) begin
               n_errors++;
               $display("FAIL store_req_fields: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000020 12345678",
                        mem_req, mem_we, mem_addr, mem_wdata);
            end
         end
         if (k == 2) begin
            n_checks++;
            if ({mem_req, mem_we, stall_m} !== 3'b000) begin
               n_errors++;
               $display("FAIL store_done_cycle: got req/we/stall %b expected 000",
                        {mem_req, mem_we, stall_m});
            end
         end
         cyc();
      end
      clear_inputs();
      n_checks++;
      if (n_stall != 2) begin
         n_errors++;
         $display("FAIL store_stall_cycles: got %0d expected 2", n_stall);
      end
      n_checks++;
      if (read_data_m !== 32'hDEAD_BEEF) begin
         n_errors++;
         $display("FAIL store_rdata_held: got %h expected deadbeef", read_data_m);
      end
   endtask

   // Load and store flags together: the store wins.
   task automatic test_store_priority();
      mem_to_reg_m = 1'b1;
      mem_write_m  = 1'b1;
      alu_out_m    = 32'h0000_0040;
      write_data_m = 32'hA5A5_A5A5;
      for (int k = 0; k < 5; k++) begin
         mem_ack   = (k == 2);
         mem_rdata = (k == 2) ? 32'h0BAD_F00D : 32'h0;
         if (k == 4) begin
            mem_to_reg_m = 1'b0;
            mem_write_m  = 1'b0;
         end
         #1;
         if (k == 1) begin
            n_checks++;
            if ({mem_req, mem_we} !== 2'b11) begin
               n_errors++;
               $display("FAIL priority_we: got req/we %b expected 11", {mem_req, mem_we});
            end
         end
         cyc();
      end
      clear_inputs();
      n_checks++;
      if (read_data_m !== 32'hDEAD_BEEF) begin
         n_errors++;
         $display("FAIL priority_rdata_held: got %h expected deadbeef", read_data_m);
      end
   endtask

   // Load at 0x13: dropped with a one-cycle addr_err.
   task automatic test_misaligned();
      mem_to_reg_m = 1'b1;
      alu_out_m    = 32'h0000_0013;
      #1;
      n_checks++;
      if ({mem_req, stall_m, addr_err} !== 3'b000) begin
         n_errors++;
         $display("FAIL misalign_cycle0: got req/stall/err %b expected 000",
                  {mem_req, stall_m, addr_err});
      end
      cyc();
      mem_to_reg_m = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, addr_err} !== 2'b01) begin
         n_errors++;
         $display("FAIL misalign_pulse: got req/err %b expected 01", {mem_req, addr_err});
      end
      cyc();
      n_checks++;
      if (addr_err !== 1'b0) begin
         n_errors++;
         $display("FAIL misalign_pulse_width: got %b expected 0", addr_err);
      end
   endtask

   // Two loads with minimum latency, one right after the other.
   task automatic test_back_to_back();
      mem_to_reg_m = 1'b1;
      alu_out_m    = 32'h0000_0100;
      for (int k = 0; k < 7; k++) begin
         mem_ack   = (k == 1) || (k == 4);
         mem_rdata = (k == 1) ? 32'h1111_1111 : (k == 4) ? 32'h2222_2222 : 32'h0;
         if (k == 3) alu_out_m = 32'h0000_0104;
         if (k == 6) mem_to_reg_m = 1'b0;
         #1;
         if (k == 2) begin
            n_checks++;
            if (stall_m !== 1'b0 || read_data_m !== 32'h1111_1111) begin
               n_errors++;
               $display("FAIL b2b_first_done: got stall=%b rdata=%h expected 0 11111111",
                        stall_m, read_data_m);
            end
         end
         if (k == 3) begin
            n_checks++;
            if ({stall_m, mem_req} !== 2'b10) begin
               n_errors++;
               $display("FAIL b2b_second_issue: got stall/req %b expected 10", {stall_m, mem_req});
            end
         end
         if (k == 4) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
               n_errors++;
               $display("FAIL b2b_second_req: got req=%b addr=%h expected 1 00000104",
                        mem_req, mem_addr);
            end
         end
         cyc();
      end
      clear_inputs();
      n_checks++;
      if (read_data_m !== 32'h2222_2222) begin
         n_errors++;
         $display("FAIL b2b_rdata: got %h expected 22222222", read_data_m);
      end
   endtask

   // A store that acks in its second request cycle, then a syscall.
   task automatic test_syscall_after_store();
      int n_go = 0;
      int first_go = -1;
      mem_write_m  = 1'b1;
      alu_out_m    = 32'h0000_0050;
      write_data_m = 32'h0000_0055;
      for (int k = 0; k < 8; k++) begin
         mem_ack = (k == 2);
         if (k == 4) begin
            mem_write_m = 1'b0;
            syscall_m   = 1'b1;
         end
         if (k == 6) syscall_m = 1'b0;
         #1;
         if (syscall_go) begin
            n_go++;
            if (first_go < 0) first_go = k;
         end
         if (k == 4) begin
            n_checks++;
            if ({stall_m, syscall_go} !== 2'b10) begin
               n_errors++;
               $display("FAIL sys_wait_cycle: got stall/go %b expected 10", {stall_m, syscall_go});
            end
         end
         cyc();
      end
      clear_inputs();
      n_checks++;
      if (n_go != 1 || first_go != 5) begin
         n_errors++;
         $display("FAIL sys_go_pulse: got width=%0d at cycle %0d expected width 1 at cycle 5",
                  n_go, first_go);
      end
   endtask

   // Reset asserted mid-ACCESS, followed by a stray ack.
   task automatic test_reset_mid_access();
      mem_to_reg_m = 1'b1;
      alu_out_m    = 32'h0000_0030;
      cyc();
      #1;
      n_checks++;
      if (mem_req !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_mid_pre: got req=%b expected 1", mem_req);
      end
      rst_n        = 1'b0;
      mem_to_reg_m = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, stall_m} !== 2'b00 || mem_addr !== 32'h0) begin
         n_errors++;
         $display("FAIL rst_mid_async: got req/stall %b addr=%h expected 00 00000000",
                  {mem_req, stall_m}, mem_addr);
      end
      cyc();
      rst_n     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      cyc();
      mem_ack = 1'b0;
      #1;
      n_checks++;
      if ({mem_req, stall_m} !== 2'b00 || read_data_m !== 32'h0) begin
         n_errors++;
         $display("FAIL rst_stray_ack: got req/stall %b rdata=%h expected 00 00000000",
                  {mem_req, stall_m}, read_data_m);
      end
      cyc();
      n_checks++;
      if ({mem_req, stall_m, syscall_go} !== 3'b000) begin
         n_errors++;
         $display("FAIL rst_idle_after: got req/stall/go %b expected 000",
                  {mem_req, stall_m, syscall_go});
      end
   endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
   // A load that never gets an ack. With TIMEOUT=4 it aborts after 4 ACCESS cycles.
   task automatic test_timeout();
      int n_req = 0;
      int n_stall = 0;
      mem_to_reg_m = 1'b1;
      alu_out_m    = 32'h0000_0060;
      mem_rdata    = 32'h7777_7777;
      for (int k = 0; k < 9; k++) begin
         if (k == 6) mem_to_reg_m = 1'b0;
         #1;
         if (mem_req) n_req++;
         if (stall_m) n_stall++;
         if (k == 5) begin
            n_checks++;
            if ({mem_req, stall_m, timeout_err} !== 3'b001) begin
               n_errors++;
               $display("FAIL timeout_done: got req/stall/terr %b expected 001",
                        {mem_req, stall_m, timeout_err});
            end
         end
         cyc();
      end
      clear_inputs();
      n_checks++;
      if (n_req != 4 || n_stall != 5) begin
         n_errors++;
         $display("FAIL timeout_cycles: got req=%0d stall=%0d expected 4 5", n_req, n_stall);
      end
      n_checks++;
      if (timeout_err !== 1'b1 || read_data_m !== 32'h0) begin
         n_errors++;
         $display("FAIL timeout_sticky: got terr=%b rdata=%h expected 1 00000000",
                  timeout_err, read_data_m);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_store();
      test_store_priority();
      test_misaligned();
      test_back_to_back();
      test_syscall_after_store();
      test_reset_mid_access();
`ifdef MEM_ACCESS_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
